// File: rtl/ram_pkg.sv
// ram_pkg: shared types and default sizing for the bus-attached program RAM.
//   ram_state_t  : controller phase (CLEAR -> LOAD -> RUN, RUN -> LOAD on reload)
//   WIDTH_DEF    : default data/bus width
//   ADDR_W_DEF   : default address width (depth = 2**ADDR_W)
package ram_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } ram_state_t;

endpackage

// File: rtl/ram_prog_bus_array.sv
// ram_array: DEPTH x WIDTH storage, one synchronous write port and one
// asynchronous read port. The array has no reset; the owner initialises it.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module ram_array #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_prog_bus.sv
// ram_prog_bus: bus-attached RAM with built-in program loader.
// After reset the array is zero-filled (CLEAR), then loaded from a
// valid/ready byte stream (LOAD), then handed to the CPU (RUN).
//   clk, rst_n    : clock, asynchronous active-low reset
//   addr          : CPU address (MAR), used only in RUN
//   wr_en, rd_en  : CPU write/read strobes, used only in RUN
//   bus           : shared tri-state data bus
//   prog_start    : reload request, honoured only in RUN
//   prog_valid    : loader byte valid
//   prog_data     : loader byte
//   prog_last     : final loader byte marker
//   prog_ready    : loader may transfer (high throughout LOAD)
//   prog_done     : one-cycle pulse in the first RUN cycle after a load
//   busy          : high whenever not in RUN
//   err_collision : sticky, rd_en and wr_en seen together in RUN
module ram_prog_bus
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  inout  logic [WIDTH-1:0]  bus,
  input  logic              prog_start,
  input  logic              prog_valid,
  input  logic [WIDTH-1:0]  prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              busy,
  output logic              err_collision
);

  ram_state_t        state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              done_q, done_next;
  logic              err_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              drive;
  logic              collide;

  ram_array #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      ptr    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      done_q <= done_next;
      if (collide) begin
        err_q <= 1'b1;
      end
    end
  end

  // Write-port mux: zero fill in CLEAR, loader in LOAD, CPU bus in RUN.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    done_next  = 1'b0;
    we         = 1'b0;
    waddr      = ptr;
    wdata      = '0;
    drive      = 1'b0;
    collide    = 1'b0;
    unique case (state)
      CLEAR: begin
        we       = 1'b1;
        ptr_next = ptr + 1'b1;
        if (ptr == '1) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        // prog_ready is constantly high here, so valid alone is a beat.
        if (prog_valid) begin
          we       = 1'b1;
          wdata    = prog_data;
          ptr_next = ptr + 1'b1;
          if (prog_last || ptr == '1) begin
            state_next = RUN;
            ptr_next   = '0;
            done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        waddr   = addr;
        wdata   = bus;
        drive   = rd_en && !wr_en;
        we      = wr_en && !rd_en;
        collide = rd_en && wr_en;
        if (prog_start) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  assign bus           = drive ? rdata : 'z;
  assign busy          = (state != RUN);
  assign prog_ready    = (state == LOAD);
  assign prog_done     = done_q;
  assign err_collision = err_q;

endmodule
